// File: rtl/bop_range_tracker.sv
// Contiguous-store run tracker with a circular range buffer and chained-load alarm.
// Optional feature macro: BOP_DESCENDING_RUN_EN (runs may also grow downwards).
module bop_range_tracker #(
  parameter int ADDR_W      = 32,
  parameter int NUM_TRK     = 2,
  parameter int RANGE_DEPTH = 8,
  parameter int MIN_RUN     = 32,
  parameter int TIMEOUT     = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         en_i,
  input  logic                         valid_i,
  input  logic [ADDR_W-1:0]            pc_i,
  input  logic                         is_store_i,
  input  logic                         is_load_i,
  input  logic [1:0]                   size_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [4:0]                   rs1_i,
  input  logic [4:0]                   rd_i,
  output logic                         hit_o,
  output logic                         alarm_o,
  output logic [$clog2(RANGE_DEPTH):0] entries_o,
  output logic                         evict_o
);

  localparam int IDX_W = (NUM_TRK > 1) ? $clog2(NUM_TRK) : 1;
  localparam int PTR_W = $clog2(RANGE_DEPTH);
  localparam int ENT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic              active;
    logic [ADDR_W-1:0] start;
    logic [ADDR_W-1:0] last;
    logic [1:0]        lsize;
    logic [31:0]       count;
    logic [AGE_W-1:0]  age;
  } trk_t;

  trk_t              trk_q [NUM_TRK];
  trk_t              trk_d [NUM_TRK];
  logic [ADDR_W-1:0] rb_start_q [RANGE_DEPTH];
  logic [ADDR_W-1:0] rb_end_q   [RANGE_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [ENT_W-1:0]  entries_q, entries_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;
  logic              last_hit_q, last_hit_d;
  logic [4:0]        last_rd_q, last_rd_d;
  logic              hit_q, hit_d;
  logic              alarm_q, alarm_d;
  logic              evict_q, evict_d;

  logic              accept, trk_store, do_evict, load_hit;
  logic [ADDR_W-1:0] bytes_a;
  logic [31:0]       bytes_c;
  logic              match_found, match_desc, idle_found, retire_found;
  logic [IDX_W-1:0]  match_idx, idle_idx, victim_idx, retire_idx, alloc_idx;
  logic              commit_req, commit_en;
  logic [ADDR_W-1:0] commit_start, commit_last, commit_end;
  logic [1:0]        commit_lsize;
  logic [31:0]       commit_count;

  // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    trk_d        = trk_q;
    wptr_d       = wptr_q;
    entries_d    = entries_q;
    last_pc_d    = last_pc_q;
    last_hit_d   = last_hit_q;
    last_rd_d    = last_rd_q;
    hit_d        = hit_q;
    alarm_d      = alarm_q;
    evict_d      = 1'b0;
    match_found  = 1'b0;
    match_desc   = 1'b0;
    match_idx    = '0;
    idle_found   = 1'b0;
    idle_idx     = '0;
    victim_idx   = '0;
    retire_found = 1'b0;
    retire_idx   = '0;
    alloc_idx    = '0;
    commit_req   = 1'b0;
    commit_start = '0;
    commit_last  = '0;
    commit_lsize = '0;
    commit_count = '0;
    load_hit     = 1'b0;

    accept    = valid_i && en_i && (pc_i != last_pc_q);
    // Stack/frame-pointer stores are spills, not buffer fills.
    trk_store = accept && is_store_i && (size_i != 2'd3) && (rs1_i != 5'd2) && (rs1_i != 5'd8);
    bytes_a   = ADDR_W'(1) << size_i;
    bytes_c   = 32'd1 << size_i;

    for (int i = 0; i < NUM_TRK; i++) begin
      if (trk_store && !match_found && trk_q[i].active) begin
        if (trk_q[i].last + (ADDR_W'(1) << trk_q[i].lsize) == addr_i) begin
          match_found = 1'b1;
          match_idx   = IDX_W'(i);
        end
`ifdef BOP_DESCENDING_RUN_EN
        else if (trk_q[i].start - bytes_a == addr_i) begin
          match_found = 1'b1;
          match_desc  = 1'b1;
          match_idx   = IDX_W'(i);
        end
`endif
      end
      if (!idle_found && !trk_q[i].active) begin
        idle_found = 1'b1;
        idle_idx   = IDX_W'(i);
      end
      if (trk_q[i].age < trk_q[victim_idx].age) victim_idx = IDX_W'(i);
      // A tracker being extended by this cycle's store is not timed out.
      if (!retire_found && trk_q[i].active && (trk_q[i].age == '0) &&
          !(match_found && match_idx == IDX_W'(i))) begin
        retire_found = 1'b1;
        retire_idx   = IDX_W'(i);
      end
    end
    do_evict = trk_store && !match_found && !idle_found;

    if (accept && !trk_store) begin
      for (int i = 0; i < NUM_TRK; i++) begin
        if (trk_q[i].active && (trk_q[i].age != '0)) trk_d[i].age = trk_q[i].age - AGE_W'(1);
      end
    end

    if (do_evict) begin
      commit_req   = 1'b1;
      commit_start = trk_q[victim_idx].start;
      commit_last  = trk_q[victim_idx].last;
      commit_lsize = trk_q[victim_idx].lsize;
      commit_count = trk_q[victim_idx].count;
      evict_d      = 1'b1;
    end else if (retire_found) begin
      commit_req   = 1'b1;
      commit_start = trk_q[retire_idx].start;
      commit_last  = trk_q[retire_idx].last;
      commit_lsize = trk_q[retire_idx].lsize;
      commit_count = trk_q[retire_idx].count;
      trk_d[retire_idx].active = 1'b0;
    end

    if (match_found) begin
      if (match_desc) begin
        trk_d[match_idx].start = addr_i;
      end else begin
        trk_d[match_idx].last  = addr_i;
        trk_d[match_idx].lsize = size_i;
      end
      trk_d[match_idx].count = trk_q[match_idx].count + bytes_c;
      trk_d[match_idx].age   = AGE_W'(TIMEOUT);
    end else if (trk_store) begin
      alloc_idx                = idle_found ? idle_idx : victim_idx;
      trk_d[alloc_idx].active  = 1'b1;
      trk_d[alloc_idx].start   = addr_i;
      trk_d[alloc_idx].last    = addr_i;
      trk_d[alloc_idx].lsize   = size_i;
      trk_d[alloc_idx].count   = bytes_c;
      trk_d[alloc_idx].age     = AGE_W'(TIMEOUT);
    end

    commit_en  = commit_req && (commit_count > 32'(MIN_RUN));
    commit_end = commit_last + (ADDR_W'(1) << commit_lsize) - ADDR_W'(1);
    if (commit_en) begin
      wptr_d    = wptr_q + PTR_W'(1);
      entries_d = (entries_q == ENT_W'(RANGE_DEPTH)) ? entries_q : entries_q + ENT_W'(1);
    end
    if (accept) last_pc_d = pc_i;

    // Lookup sees only the registered buffer, so a same-cycle commit is invisible.
    for (int j = 0; j < RANGE_DEPTH; j++) begin
      if ((ENT_W'(j) < entries_q) && (rb_start_q[j] <= addr_i) && (addr_i <= rb_end_q[j]))
        load_hit = 1'b1;
    end
    if (valid_i && is_load_i) begin
      hit_d = load_hit;
      if (load_hit) begin
        if (last_hit_q && (rs1_i == last_rd_q)) alarm_d = 1'b1;
        last_hit_d = 1'b1;
        last_rd_d  = rd_i;
      end else begin
        last_hit_d = 1'b0;
        last_rd_d  = '0;
      end
    end

    if (clear_i) begin
      for (int i = 0; i < NUM_TRK; i++) trk_d[i] = '0;
      commit_en  = 1'b0;
      wptr_d     = '0;
      entries_d  = '0;
      last_pc_d  = '0;
      last_hit_d = 1'b0;
      last_rd_d  = '0;
      hit_d      = 1'b0;
      alarm_d    = 1'b0;
      evict_d    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the blocking ones above are combinational.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_TRK; i++) trk_q[i] <= '0;
      wptr_q     <= '0;
      entries_q  <= '0;
      last_pc_q  <= '0;
      last_hit_q <= 1'b0;
      last_rd_q  <= '0;
      hit_q      <= 1'b0;
      alarm_q    <= 1'b0;
      evict_q    <= 1'b0;
    end else begin
      trk_q      <= trk_d;
      wptr_q     <= wptr_d;
      entries_q  <= entries_d;
      last_pc_q  <= last_pc_d;
      last_hit_q <= last_hit_d;
      last_rd_q  <= last_rd_d;
      hit_q      <= hit_d;
      alarm_q    <= alarm_d;
      evict_q    <= evict_d;
    end
  end

  // NOTE: the range storage has no reset; entries_q gates every read, so stale contents never match.
  always_ff @(posedge clk_i) begin
    if (commit_en) begin
      rb_start_q[wptr_q] <= commit_start;
      rb_end_q[wptr_q]   <= commit_end;
    end
  end

  assign hit_o     = hit_q;
  assign alarm_o   = alarm_q;
  assign entries_o = entries_q;
  assign evict_o   = evict_q;

endmodule

// File: tb/tb_bop_range_tracker.sv
// Self-checking bench for bop_range_tracker: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_bop_range_tracker;
  localparam int ADDR_W      = 32;
  localparam int NUM_TRK     = 2;
  localparam int RANGE_DEPTH = 8;
  localparam int MIN_RUN     = 32;
  localparam int TIMEOUT     = 10;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        en_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        is_store_i = 1'b0;
  logic        is_load_i = 1'b0;
  logic [1:0]  size_i = '0;
  logic [31:0] addr_i = '0;
  logic [4:0]  rs1_i = '0;
  logic [4:0]  rd_i = '0;
  logic        hit_o, alarm_o, evict_o;
  logic [3:0]  entries_o;

  always #5 clk_i = ~clk_i;

  bop_range_tracker #(
    .ADDR_W(ADDR_W), .NUM_TRK(NUM_TRK), .RANGE_DEPTH(RANGE_DEPTH),
    .MIN_RUN(MIN_RUN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .en_i(en_i), .valid_i(valid_i),
    .pc_i(pc_i), .is_store_i(is_store_i), .is_load_i(is_load_i), .size_i(size_i),
    .addr_i(addr_i), .rs1_i(rs1_i), .rd_i(rd_i), .hit_o(hit_o), .alarm_o(alarm_o),
    .entries_o(entries_o), .evict_o(evict_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          act;
    logic [31:0] st;
    logic [31:0] la;
    int          lsz;
    longint      cnt;
    int          age;
  } mtrk_t;

  mtrk_t       mt [NUM_TRK];
  logic [31:0] rq_lo [$];
  logic [31:0] rq_hi [$];
  bit          m_hit, m_alarm, m_evict, m_lhit;
  logic [4:0]  m_lrd;
  logic [31:0] m_lpc;

  task automatic model_reset();
    for (int t = 0; t < NUM_TRK; t++) begin
      mt[t].act = 0; mt[t].st = '0; mt[t].la = '0; mt[t].lsz = 0; mt[t].cnt = 0; mt[t].age = 0;
    end
    rq_lo.delete();
    rq_hi.delete();
    m_hit = 0; m_alarm = 0; m_evict = 0; m_lhit = 0; m_lrd = '0; m_lpc = '0;
  endtask

  // The buffer is simply the most recent RANGE_DEPTH qualifying runs.
  task automatic m_commit(input int t);
    if (mt[t].cnt > MIN_RUN) begin
      rq_lo.push_back(mt[t].st);
      rq_hi.push_back(mt[t].la + (32'd1 << mt[t].lsz) - 32'd1);
      if (rq_lo.size() > RANGE_DEPTH) begin
        void'(rq_lo.pop_front());
        void'(rq_hi.pop_front());
      end
    end
  endtask

  task automatic model_step();
    bit acc, tst, h, evicted, desc;
    int mi, ret, idl, vic;
    logic [31:0] bytes;
    if (clear_i) begin
      model_reset();
      return;
    end
    if (valid_i && is_load_i) begin
      h = 0;
      for (int k = 0; k < rq_lo.size(); k++)
        if (addr_i >= rq_lo[k] && addr_i <= rq_hi[k]) h = 1;
      if (h) begin
        if (m_lhit && rs1_i == m_lrd) m_alarm = 1;
        m_lhit = 1;
        m_lrd  = rd_i;
      end else begin
        m_lhit = 0;
        m_lrd  = '0;
      end
      m_hit = h;
    end
    m_evict = 0;
    evicted = 0;
    desc    = 0;
    acc   = valid_i && en_i && (pc_i != m_lpc);
    tst   = acc && is_store_i && size_i != 2'd3 && rs1_i != 5'd2 && rs1_i != 5'd8;
    bytes = 32'd1 << size_i;
    mi = -1;
    if (tst) begin
      for (int t = 0; t < NUM_TRK; t++) begin
        if (mi < 0 && mt[t].act) begin
          if (mt[t].la + (32'd1 << mt[t].lsz) == addr_i) mi = t;
`ifdef BOP_DESCENDING_RUN_EN
          else if (mt[t].st - bytes == addr_i) begin mi = t; desc = 1; end
`endif
        end
      end
    end
    ret = -1;
    for (int t = 0; t < NUM_TRK; t++)
      if (ret < 0 && mt[t].act && mt[t].age == 0 && t != mi) ret = t;
    if (acc && !tst)
      for (int t = 0; t < NUM_TRK; t++)
        if (mt[t].act && mt[t].age > 0) mt[t].age--;
    if (tst) begin
      if (mi >= 0) begin
        if (desc) mt[mi].st = addr_i;
        else begin mt[mi].la = addr_i; mt[mi].lsz = int'(size_i); end
        mt[mi].cnt += longint'(bytes);
        mt[mi].age = TIMEOUT;
      end else begin
        idl = -1;
        for (int t = 0; t < NUM_TRK; t++) if (idl < 0 && !mt[t].act) idl = t;
        if (idl < 0) begin
          vic = 0;
          for (int t = 1; t < NUM_TRK; t++) if (mt[t].age < mt[vic].age) vic = t;
          m_commit(vic);
          m_evict = 1;
          evicted = 1;
          idl = vic;
        end
        mt[idl].act = 1; mt[idl].st = addr_i; mt[idl].la = addr_i;
        mt[idl].lsz = int'(size_i); mt[idl].cnt = longint'(bytes); mt[idl].age = TIMEOUT;
      end
    end
    if (!evicted && ret >= 0) begin
      m_commit(ret);
      mt[ret].act = 0;
    end
    if (acc) m_lpc = pc_i;
  endtask

  always @(negedge rst_ni) model_reset();

  // Compare process: advance the model on each edge, check outputs just after it.
  always @(posedge clk_i) begin
    if (!rst_ni) model_reset();
    else model_step();
    #1;
    check("cmp_hit", 32'(hit_o), 32'(m_hit));
    check("cmp_alarm", 32'(alarm_o), 32'(m_alarm));
    check("cmp_entries", 32'(entries_o), 32'(rq_lo.size()));
    check("cmp_evict", 32'(evict_o), 32'(m_evict));
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] pc_ctr = 32'h100;

  task automatic drive(input bit v, input bit st, input bit ld, input logic [1:0] sz,
                       input logic [31:0] a, input logic [4:0] r1, input logic [4:0] rd,
                       input bit new_pc);
    @(negedge clk_i);
    if (new_pc) pc_ctr += 32'd4;
    clear_i = 0; valid_i = v; is_store_i = st; is_load_i = ld; size_i = sz;
    addr_i = a; rs1_i = r1; rd_i = rd; pc_i = pc_ctr;
  endtask

  task automatic sto(input logic [31:0] a, input logic [1:0] sz);
    drive(1, 1, 0, sz, a, 5'd10, 5'd0, 1);
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) drive(1, 0, 0, 2'd2, 32'h0, 5'd1, 5'd1, 1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 2'd0, 32'h0, 5'd0, 5'd0, 0);
  endtask

  task automatic lod(input logic [31:0] a, input logic [4:0] r1, input logic [4:0] rd);
    drive(1, 0, 1, 2'd2, a, r1, rd, 1);
  endtask

  // Let the last driven instruction take effect, then park the inputs idle.
  task automatic post();
    @(posedge clk_i);
    #2;
    valid_i = 0;
    clear_i = 0;
  endtask

  task automatic do_clear();
    @(negedge clk_i);
    valid_i = 0;
    clear_i = 1;
    post();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] sptr [3];

  initial begin
    repeat (3) @(posedge clk_i);
    #2;
    check("reset_hit", 32'(hit_o), 32'd0);
    check("reset_alarm", 32'(alarm_o), 32'd0);
    check("reset_entries", 32'(entries_o), 32'd0);
    check("reset_evict", 32'(evict_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1;

    // Ascending 40-byte run commits as [0x1000, 0x1027].
    for (int k = 0; k < 40; k++) sto(32'h1000 + 32'(k), 2'd0);
    nop(11);
    post();
    check("asc_entries", 32'(entries_o), 32'd1);
    lod(32'h0FFF, 5'd9, 5'd3); post(); check("below_lo_miss", 32'(hit_o), 32'd0);
    lod(32'h1027, 5'd9, 5'd3); post(); check("hi_edge_hit", 32'(hit_o), 32'd1);
    lod(32'h1028, 5'd9, 5'd3); post(); check("above_hi_miss", 32'(hit_o), 32'd0);
    lod(32'h1000, 5'd9, 5'd3); post(); check("lo_edge_hit", 32'(hit_o), 32'd1);
    lod(32'h1010, 5'd9, 5'd5); post();
    check("hit_0x1010", 32'(hit_o), 32'd1);
    check("no_chain_alarm", 32'(alarm_o), 32'd0);
    lod(32'h1020, 5'd5, 5'd7); post(); check("chain_alarm", 32'(alarm_o), 32'd1);
    lod(32'h9000, 5'd7, 5'd1); post();
    check("miss_hit", 32'(hit_o), 32'd0);
    check("alarm_sticky", 32'(alarm_o), 32'd1);
    do_clear();
    check("clear_alarm", 32'(alarm_o), 32'd0);
    check("clear_entries", 32'(entries_o), 32'd0);

    // Short run dropped.
    for (int k = 0; k < 20; k++) sto(32'h1100 + 32'(k), 2'd0);
    nop(11);
    post();
    check("short_dropped", 32'(entries_o), 32'd0);

    // Exactly MIN_RUN bytes, plus a repeated-PC store that must be ignored.
    for (int k = 0; k < 32; k++) sto(32'h5000 + 32'(k), 2'd0);
    drive(1, 1, 0, 2'd0, 32'h5020, 5'd10, 5'd0, 0);
    nop(11);
    post();
    check("min_run_dropped", 32'(entries_o), 32'd0);
    for (int k = 0; k < 33; k++) sto(32'h5100 + 32'(k), 2'd0);
    nop(11);
    post();
    check("min_run_plus1", 32'(entries_o), 32'd1);

    // Interleaved word and byte runs.
    do_clear();
    for (int k = 0; k < 40; k++) begin
      sto(32'h3000 + 32'(k), 2'd0);
      if (k % 4 == 3) sto(32'h2000 + 32'((k / 4) * 4), 2'd2);
    end
    nop(11);
    idle(2);
    post();
    check("interleave_entries", 32'(entries_o), 32'd2);
    lod(32'h2027, 5'd1, 5'd1); post(); check("sw_run_hit", 32'(hit_o), 32'd1);
    lod(32'h3000, 5'd1, 5'd2); post(); check("sb_run_hit", 32'(hit_o), 32'd1);

    // Eviction of the lowest-age tracker.
    do_clear();
    for (int k = 0; k < 40; k++) sto(32'h6000 + 32'(k), 2'd0);
    nop(2);
    for (int k = 0; k < 40; k++) sto(32'h7000 + 32'(k), 2'd0);
    sto(32'h4000, 2'd0);
    post();
    check("evict_pulse", 32'(evict_o), 32'd1);
    check("evict_entries", 32'(entries_o), 32'd1);
    post();
    check("evict_one_cycle", 32'(evict_o), 32'd0);
    lod(32'h6000, 5'd1, 5'd1); post(); check("evicted_run_hit", 32'(hit_o), 32'd1);
    lod(32'h7000, 5'd1, 5'd1); post(); check("live_run_miss", 32'(hit_o), 32'd0);

    // Wrap: RANGE_DEPTH+1 commits.
    do_clear();
    for (int r = 0; r < RANGE_DEPTH + 1; r++) begin
      for (int k = 0; k < 33; k++) sto(32'h8000 + 32'(r * 256 + k), 2'd0);
      nop(11);
    end
    post();
    check("wrap_entries", 32'(entries_o), 32'd8);
    lod(32'h8000, 5'd1, 5'd1); post(); check("wrap_oldest_gone", 32'(hit_o), 32'd0);
    lod(32'h8100, 5'd1, 5'd1); post(); check("wrap_second_hit", 32'(hit_o), 32'd1);
    lod(32'h8820, 5'd1, 5'd1); post(); check("wrap_newest_hit", 32'(hit_o), 32'd1);
    lod(32'h8821, 5'd1, 5'd1); post(); check("wrap_newest_end", 32'(hit_o), 32'd0);

    // Random traffic over three store streams.
    do_clear();
    sptr[0] = 32'h10000; sptr[1] = 32'h20000; sptr[2] = 32'h30000;
    for (int c = 0; c < 2500; c++) begin
      int r, s;
      logic [1:0] sz;
      logic [4:0] r1;
      bit np;
      r  = $urandom_range(0, 199);
      s  = $urandom_range(0, 2);
      np = ($urandom_range(0, 24) != 0);
      if (c == 1200) begin
        @(negedge clk_i);
        rst_ni = 0;
        #1;
        check("async_rst_entries", 32'(entries_o), 32'd0);
        check("async_rst_alarm", 32'(alarm_o), 32'd0);
        check("async_rst_hit", 32'(hit_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1;
      end
      if (r < 110) begin
        sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        r1 = ($urandom_range(0, 15) == 0) ? (($urandom_range(0, 1) == 0) ? 5'd2 : 5'd8) : 5'd10;
        if ($urandom_range(0, 49) == 0) sptr[s] = 32'h10000 + 32'($urandom_range(0, 63)) * 32'h400;
        drive(1, 1, 0, sz, sptr[s], r1, 5'd0, np);
        if (sz != 2'd3) sptr[s] += 32'd1 << sz;
      end else if (r < 150) begin
        drive(1, 0, 1, 2'd2, sptr[s] - 32'($urandom_range(1, 80)),
              5'($urandom_range(3, 6)), 5'($urandom_range(3, 6)), np);
      end else if (r < 185) begin
        drive(1, 0, 0, 2'd2, 32'h0, 5'd1, 5'd1, np);
      end else if (r < 198) begin
        drive(0, 0, 0, 2'd0, 32'h0, 5'd0, 5'd0, 0);
      end else begin
        drive(0, 0, 0, 2'd0, 32'h0, 5'd0, 5'd0, 0);
        if ($urandom_range(0, 1) == 0) clear_i = 1;
      end
      en_i = ($urandom_range(0, 29) != 0);
    end
    en_i = 1;
    idle(30);
    post();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
